audio_sample_queue: RTL and testbench
=====================================

// Module: audio_sample_queue
// PURPOSE
//  Circular sample buffer feeding the FIR band filters. Stores incoming stereo samples
//  and, on each new sample once full, streams the last DEPTH-1 samples oldest->newest
//  while asserting sequencing. One cycle is issued per sample, so the FIR MAC sees one
//  sample per coefficient. Sits between the audio codec receive path and the FIR banks.
// PARAMETERS
//  DEPTH  1021  buffer slots; window length = DEPTH-1 samples (1020 default)
//  AW     10    pointer width; 2**AW >= DEPTH
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  wrt_smpl   in   1   1-cycle strobe: new stereo sample valid on lft_smpl/rght_smpl
//  lft_smpl   in   16  signed left sample to store
//  rght_smpl  in   16  signed right sample to store
//  lft_out    out  16  signed left sample streamed to FIR lft_in
//  rght_out   out  16  signed right sample streamed to FIR rght_in
//  sequencing out  1   high for exactly DEPTH-1 consecutive cycles per readout
// BEHAVIOUR
//  - Storage: dual-port RAM, DEPTH x 32 {lft,rght}, sync write, sync read (1-cycle).
//    Contents not reset. new_ptr (write), old_ptr (window start), rd_ptr, rd_cnt, full.
//  - Reset (async): new_ptr=old_ptr=rd_ptr=0, rd_cnt=0, full=0, state=IDLE,
//    sequencing=0, lft_out=rght_out=0.
//  - Write (IDLE only): on wrt_smpl, mem[new_ptr]<={lft_smpl,rght_smpl};
//    new_ptr <= (new_ptr==DEPTH-1) ? 0 : new_ptr+1. If full already set, old_ptr
//    increments with same wrap in the same cycle.
//  - Fill: writes 1..DEPTH-2 produce no readout. Write DEPTH-1 (new_ptr==DEPTH-2
//    before write) sets full and triggers the first readout with old_ptr=0.
//  - Every write with full set (after the pointer update) triggers a readout.
//  - FSM states: IDLE, PRIME, READ.
//    IDLE: wrt_smpl & readout-trigger -> PRIME; else stay.
//    PRIME (1 cycle): rd_ptr<=old_ptr (post-update), issue read; -> READ.
//    READ: sequencing=1; each cycle lft_out/rght_out = mem[rd_ptr] of prior issue,
//      rd_ptr advances with wrap at DEPTH-1, rd_cnt++; after DEPTH-1 outputs -> IDLE.
//  - Latency: wrt_smpl sampled at edge T -> sequencing high from T+2 through
//    T+DEPTH (inclusive); first output = oldest sample, last = sample just written.
//  - wrt_smpl while in PRIME or READ is ignored: no write, no pointer change, no
//    restart, readout length unchanged.
//  - Outputs hold last streamed value while sequencing=0.
//  - Samples pass unmodified (no scaling/saturation); full signed range preserved.
//  - Reset mid-readout: sequencing drops immediately; buffer must refill
//    (DEPTH-1 writes) before next readout.
// TESTING (bench uses DEPTH=8, AW=3: window=7)
//  1 Reset: assert rst_n=0 -> sequencing=0, lft_out=rght_out=0x0000 with no clk edge.
//  2 Fill: write lft=1..6 (rght=-lft) -> sequencing never high; write 7 -> sequencing
//    high 7 cycles starting T+2, lft_out 1,2..7, rght_out -1..-7.
//  3 Wrap: continue writes 8,9,10 -> each readout 7 cycles; after 10 lft_out 4..10
//    (crosses index wrap 7->0); sequencing low between readouts.
//  4 Collision: wrt_smpl=11 pulsed at 3rd READ cycle -> ignored, readout still 7
//    cycles; next write 12 -> outputs 5..10,12 (11 absent).
//  5 Reset mid-readout at 4th READ cycle -> sequencing=0 same cycle; 6 writes give no
//    readout, 7th gives readout of those 7 samples.
//  6 Extremes: write 0x8000/0x7FFF alternating -> streamed bit-exact, sign intact.

Source files
------------

// File: rtl/audio_sample_queue.sv
// Circular stereo sample buffer: on each new sample once full, streams the last
// DEPTH-1 samples oldest->newest, one per cycle, with sequencing asserted.
module audio_sample_queue #(
   parameter int DEPTH = 1021,
   parameter int AW    = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wrt_smpl,
   input  logic signed [15:0] lft_smpl,
   input  logic signed [15:0] rght_smpl,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               sequencing
);

   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [AW-1:0] FILL_END = AW'(DEPTH - 2);

   typedef enum logic [1:0] {IDLE, PRIME, READ} state_t;

   state_t        state, next_state;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   rd_data;
   logic [AW-1:0] new_ptr, old_ptr, rd_ptr, rd_cnt, rd_addr;
   logic          full, wr_en, trigger;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign wr_en   = wrt_smpl && (state == IDLE);
   assign trigger = full || (new_ptr == FILL_END);
   // PRIME fetches the window start; READ prefetches the next slot each cycle.
   assign rd_addr = (state == PRIME) ? old_ptr : rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[new_ptr] <= {lft_smpl, rght_smpl};
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (wr_en && trigger) next_state = PRIME;
         PRIME:   next_state = READ;
         READ:    if (rd_cnt == FILL_END) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_ptr    <= '0;
         old_ptr    <= '0;
         rd_ptr     <= '0;
         rd_cnt     <= '0;
         full       <= 1'b0;
         sequencing <= 1'b0;
         lft_out    <= '0;
         rght_out   <= '0;
      end else begin
         sequencing <= 1'b0;
         if (wr_en) begin
            new_ptr <= inc(new_ptr);
            if (full)
               old_ptr <= inc(old_ptr);
            else if (new_ptr == FILL_END)
               full <= 1'b1;
         end
         case (state)
            PRIME: begin
               rd_ptr <= inc(old_ptr);
               rd_cnt <= '0;
            end
            READ: begin
               lft_out    <= rd_data[31:16];
               rght_out   <= rd_data[15:0];
               sequencing <= 1'b1;
               rd_ptr     <= inc(rd_ptr);
               rd_cnt     <= rd_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_sample_queue.sv
// Directed bench for audio_sample_queue with DEPTH=8 (7-sample window).
module tb_audio_sample_queue;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               wrt_smpl = 1'b0;
   logic signed [15:0] lft_smpl = '0;
   logic signed [15:0] rght_smpl = '0;
   logic signed [15:0] lft_out, rght_out;
   logic               sequencing;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] hist[$];

   audio_sample_queue #(.DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl),
      .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
      .lft_out(lft_out), .rght_out(rght_out), .sequencing(sequencing)
   );

   always #5 clk = ~clk;

   // One write strobe, then 12 cycles of observation. Window of expected samples
   // is the last 7 writes since reset.
   task automatic write_smpl(input logic [15:0] l, input logic [15:0] r,
                             input int collide_at, input int rst_at);
      logic       exp_seq;
      logic       exp_read;
      logic [31:0] e;
      @(negedge clk);
      wrt_smpl = 1'b1; lft_smpl = l; rght_smpl = r;
      @(posedge clk);
      hist.push_back({l, r});
      if (hist.size() > 7) void'(hist.pop_front());
      exp_read = (hist.size() == 7);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         wrt_smpl = 1'b0;
         exp_seq = exp_read && (n >= 2) && (n <= 8);
         n_cmp++;
         if (sequencing !== exp_seq) begin
            n_fail++;
            $display("FAIL seq w=%0d n=%0d got %b want %b", $signed(l), n, sequencing, exp_seq);
         end
         if (exp_seq) begin
            e = hist[n-2];
            n_cmp++;
            if (lft_out !== e[31:16] || rght_out !== e[15:0]) begin
               n_fail++;
               $display("FAIL data w=%0d n=%0d got %h/%h want %h/%h", $signed(l), n,
                        lft_out, rght_out, e[31:16], e[15:0]);
            end
         end
         if (n == collide_at) begin
            wrt_smpl = 1'b1; lft_smpl = 16'sd11; rght_smpl = -16'sd11;
         end
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (sequencing !== 1'b0 || lft_out !== 16'h0000 || rght_out !== 16'h0000) begin
               n_fail++;
               $display("FAIL mid_reset got seq=%b %h/%h want 0 0000/0000",
                        sequencing, lft_out, rght_out);
            end
            @(negedge clk);
            rst_n = 1'b1;
            hist.delete();
            return;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sequencing !== 1'b0 || lft_out !== 16'h0000 || rght_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset got seq=%b %h/%h want 0 0000/0000", sequencing, lft_out, rght_out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 7; i++)
         write_smpl(16'(i), 16'(-i), -1, -1);
   endtask

   task automatic test_wrap();
      for (int i = 8; i <= 9; i++)
         write_smpl(16'(i), 16'(-i), -1, -1);
   endtask

   task automatic test_collision();
      write_smpl(16'd10, 16'(-10), 3, -1);
      write_smpl(16'd12, 16'(-12), -1, -1);
   endtask

   task automatic test_reset_mid_readout();
      write_smpl(16'd13, 16'(-13), -1, 4);
      for (int i = 21; i <= 27; i++)
         write_smpl(16'(i), 16'(-i), -1, -1);
   endtask

   task automatic test_extremes();
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0) write_smpl(16'h8000, 16'h7FFF, -1, -1);
         else            write_smpl(16'h7FFF, 16'h8000, -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_collision();
      test_reset_mid_readout();
      test_extremes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
